adc_sample_packer: RTL

- Sits in the ADC clock domain between the test/ADC data generator (10-bit samples every clock) and the sample FIFO buffer.
- Densely packs 10-bit samples into 16-bit words: 8 samples become 5 words, so USB bandwidth is 62.5% of zero-extended transfer.
- Emits a write strobe per completed word and a group-start flag, so the FIFO writes only valid words and host software can realign.
- Gated by the FX3 collect-data signal; a legacy unpacked mode is selectable by parameter.

---
 rtl/adc_sample_packer_pkg.sv | 27 ++
 rtl/adc_sample_packer_accumulator.sv | 40 ++++
 rtl/adc_sample_packer.sv | 83 ++++++++
 3 files changed

// File: rtl/adc_sample_packer_pkg.sv
// Shared constants and types for the 10-to-16 ADC sample packer.
package adc_sample_packer_pkg;

    localparam int SAMPLE_WIDTH  = 10;
    localparam int WORD_WIDTH    = 16;
    localparam int GROUP_SAMPLES = 8;
    localparam int GROUP_WORDS   = 5;
    localparam int ACC_WIDTH     = 26;
    localparam int FILL_WIDTH    = 5;

    // bit n set = a word completes on phase n
    localparam logic [GROUP_SAMPLES-1:0] EMIT_MASK = 8'b11011010;

    typedef logic [SAMPLE_WIDTH-1:0] sample_t;
    typedef logic [WORD_WIDTH-1:0]   word_t;
    typedef logic [2:0]              phase_t;

    function automatic sample_t sign_conv(input sample_t s, input bit en);
        sample_t r;
        r = s;
        if (en) begin
            r[SAMPLE_WIDTH-1] = ~s[SAMPLE_WIDTH-1];
        end
        return r;
    endfunction

endpackage

// File: rtl/adc_sample_packer_accumulator.sv
// Little-endian bit accumulator: appends 10-bit samples above the residue
// and hands out the low 16 bits when a word completes.
module packer_accumulator
    import adc_sample_packer_pkg::*;
(
    input  logic    clock,
    input  logic    nReset,
    input  logic    i_clear,
    input  logic    i_shift,
    input  logic    i_emit,
    input  sample_t i_sample,
    output word_t   o_word
);

    logic [ACC_WIDTH-1:0]  r_acc;
    logic [FILL_WIDTH-1:0] r_fill;
    logic [ACC_WIDTH-1:0]  w_merged;

    assign w_merged = r_acc | (ACC_WIDTH'(i_sample) << r_fill);
    assign o_word   = w_merged[WORD_WIDTH-1:0];

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            r_acc  <= '0;
            r_fill <= '0;
        end else if (i_clear) begin
            r_acc  <= '0;
            r_fill <= '0;
        end else if (i_shift) begin
            if (i_emit) begin
                r_acc  <= w_merged >> WORD_WIDTH;
                r_fill <= r_fill - FILL_WIDTH'(WORD_WIDTH - SAMPLE_WIDTH);
            end else begin
                r_acc  <= w_merged;
                r_fill <= r_fill + FILL_WIDTH'(SAMPLE_WIDTH);
            end
        end
    end

endmodule

// File: rtl/adc_sample_packer.sv
// Packs 10-bit ADC samples into 16-bit FIFO words (8 samples -> 5 words),
// or zero-extends one sample per word in legacy mode.
module adc_sample_packer
    import adc_sample_packer_pkg::*;
#(
    parameter bit PACKED       = 1'b1,
    parameter bit SIGN_CONVERT = 1'b0
) (
    input  logic        clock,
    input  logic        nReset,
    input  logic        isWriting,
    input  logic [9:0]  dataIn,
    output logic [15:0] dataOut,
    output logic        dataOutValid,
    output logic        groupStart,
    output logic [31:0] sampleCount
);

    phase_t      r_phase;
    word_t       r_data;
    logic        r_valid;
    logic        r_group;
    logic [31:0] r_sample_count;

    sample_t w_sample;
    word_t   w_word;
    logic    w_emit;
    logic    w_first;
    logic    w_fire;

    assign w_sample = sign_conv(dataIn, SIGN_CONVERT);

    // Packed mode: word 0 of a group completes on phase 1.
    // Legacy mode: the phase counter simply counts words mod 8.
    always_comb begin
        w_emit  = 1'b1;
        w_first = (r_phase == 3'd0);
        if (PACKED) begin
            w_emit  = EMIT_MASK[r_phase];
            w_first = (r_phase == 3'd1);
        end
    end

    assign w_fire = isWriting & w_emit;

    packer_accumulator u_acc (
        .clock    (clock),
        .nReset   (nReset),
        .i_clear  (~isWriting),
        .i_shift  (isWriting & PACKED),
        .i_emit   (w_emit),
        .i_sample (w_sample),
        .o_word   (w_word)
    );

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            r_phase        <= '0;
            r_data         <= '0;
            r_valid        <= 1'b0;
            r_group        <= 1'b0;
            r_sample_count <= '0;
        end else begin
            r_valid <= w_fire;
            r_group <= w_fire & w_first;
            if (w_fire) begin
                r_data <= PACKED ? w_word : WORD_WIDTH'(w_sample);
            end
            if (isWriting) begin
                r_phase        <= r_phase + 3'd1;
                r_sample_count <= r_sample_count + 32'd1;
            end else begin
                r_phase <= '0;
            end
        end
    end

    assign dataOut      = r_data;
    assign dataOutValid = r_valid;
    assign groupStart   = r_group;
    assign sampleCount  = r_sample_count;

endmodule
